traffic_lamp_monitor: RTL

- Downstream stage of the traffic-light FSM. Consumes its per-direction 2-bit light codes and decodes them to one-hot lamp drives.
- Independently checks safety rules: conflicting greens, illegal colour sequence, short yellow, illegal code.
- On any violation, latches a fault and forces both directions to flashing red until cleared by an operator.
- Last block before the lamp output pads.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/traffic_dir_checker.sv | 65 ++++++
 rtl/traffic_lamp_monitor.sv | 119 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic-light lamp monitor.
//   - light codes as driven by the upstream traffic-light FSM
//   - one-hot lamp drive patterns {R,Y,G}
//   - fault_cause bit positions
//   - monitor state enum
package traffic_pkg;

    localparam logic [1:0] GREEN   = 2'b00;
    localparam logic [1:0] YELLOW  = 2'b01;
    localparam logic [1:0] RED     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam int CAUSE_CONFLICT = 0;
    localparam int CAUSE_SEQ      = 1;
    localparam int CAUSE_SHORTY   = 2;
    localparam int CAUSE_ILLEGAL  = 3;

    typedef enum logic {
        NORMAL = 1'b0,
        FLASH  = 1'b1
    } monitor_state_t;

    function automatic logic [2:0] decode_lamp(input logic [1:0] code);
        case (code)
            GREEN:   decode_lamp = LAMP_G;
            YELLOW:  decode_lamp = LAMP_Y;
            RED:     decode_lamp = LAMP_R;
            default: decode_lamp = LAMP_OFF;
        endcase
    endfunction

endpackage

// File: rtl/traffic_dir_checker.sv
// traffic_dir_checker: per-direction rule checker.
// Keeps the previous sampled code and the consecutive-yellow count, and
// flags sequence / short-yellow / illegal-code conditions for the current
// sample. Flags are raw; the top decides whether they are acted upon.
// Ports:
//   clk, rst     clock, async active-high reset
//   cur          current light code from the upstream FSM
//   seq_err      G->R, Y->G or R->Y transition (ignored around code 11)
//   shorty_err   Y->R with fewer than MIN_YELLOW yellow samples
//   illegal      cur is code 11
//   is_red       cur is RED or 11 (11 counts as red for conflict checking)
//   lamp         decoded lamp pattern for cur
module traffic_dir_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cur,
    output logic       seq_err,
    output logic       shorty_err,
    output logic       illegal,
    output logic       is_red,
    output logic [2:0] lamp
);

    localparam int         YW   = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] YMAX = YW'(MIN_YELLOW);

    logic [1:0]    prev;
    logic [YW-1:0] ycnt;

    // prev/ycnt track the input in every monitor state, so after a fault
    // clear the history is already current. The clear condition requires
    // cur in {G,R}, which forces ycnt to 0 on that edge by itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= RED;
            ycnt <= '0;
        end else begin
            prev <= cur;
            if (cur != YELLOW)
                ycnt <= '0;
            else if (prev != YELLOW)
                ycnt <= YW'(1);
            else if (ycnt != YMAX)
                ycnt <= ycnt + YW'(1);
        end
    end

    always_comb begin
        seq_err = 1'b0;
        if (prev != ILLEGAL && cur != ILLEGAL)
            seq_err = (prev == GREEN  && cur == RED)   ||
                      (prev == YELLOW && cur == GREEN) ||
                      (prev == RED    && cur == YELLOW);
    end

    assign shorty_err = (prev == YELLOW) && (cur == RED) && (ycnt < YMAX);
    assign illegal    = (cur == ILLEGAL);
    assign is_red     = (cur == RED) || (cur == ILLEGAL);
    assign lamp       = decode_lamp(cur);

endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: decodes NS/EW light codes to lamp drives and
// enforces safety rules. Any violation latches a fault and flashes red on
// both directions until an operator clear is accepted in a safe state.
// Ports:
//   clk, rst          clock, async active-high reset
//   ns_code, ew_code  2-bit light codes (00 G, 01 Y, 10 R, 11 illegal)
//   fault_clr         level request to leave fault mode
//   ns_lamp, ew_lamp  lamp drive {R,Y,G}
//   fault             high while flashing
//   fault_cause       sticky cause bits {illegal, short yellow, sequence, conflict}
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 5,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ns_code,
    input  logic [1:0] ew_code,
    input  logic       fault_clr,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       fault,
    output logic [3:0] fault_cause
);

    localparam int            FW        = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0] HALF_LAST = FW'(FLASH_HALF - 1);

    logic       ns_seq, ns_shorty, ns_ill, ns_red;
    logic       ew_seq, ew_shorty, ew_ill, ew_red;
    logic [2:0] ns_dec, ew_dec;

    traffic_dir_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ns (
        .clk(clk), .rst(rst), .cur(ns_code),
        .seq_err(ns_seq), .shorty_err(ns_shorty), .illegal(ns_ill),
        .is_red(ns_red), .lamp(ns_dec)
    );

    traffic_dir_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ew (
        .clk(clk), .rst(rst), .cur(ew_code),
        .seq_err(ew_seq), .shorty_err(ew_shorty), .illegal(ew_ill),
        .is_red(ew_red), .lamp(ew_dec)
    );

    monitor_state_t state, state_d;
    logic [3:0]     cause_now;
    logic           violation;
    logic           clr_ok;
    logic [2:0]     ns_q, ew_q;
    logic [FW-1:0]  fcnt;
    logic           phase;

    always_comb begin
        cause_now                 = '0;
        cause_now[CAUSE_CONFLICT] = !ns_red && !ew_red;
        cause_now[CAUSE_SEQ]      = ns_seq | ew_seq;
        cause_now[CAUSE_SHORTY]   = ns_shorty | ew_shorty;
        cause_now[CAUSE_ILLEGAL]  = ns_ill | ew_ill;
    end

    assign violation = |cause_now;

    // Safe to leave fault mode only with both directions steady G or R and
    // at least one of them red.
    assign clr_ok = fault_clr &&
                    (ns_code == GREEN || ns_code == RED) &&
                    (ew_code == GREEN || ew_code == RED) &&
                    (ns_code == RED || ew_code == RED);

    always_comb begin
        state_d = state;
        case (state)
            NORMAL:  if (violation) state_d = FLASH;
            FLASH:   if (clr_ok)    state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= NORMAL;
            ns_q        <= LAMP_R;
            ew_q        <= LAMP_R;
            fault_cause <= '0;
            fcnt        <= '0;
            phase       <= 1'b1;
        end else begin
            state <= state_d;
            if (state == NORMAL) begin
                if (violation) begin
                    fault_cause <= cause_now;
                    fcnt        <= '0;
                    phase       <= 1'b1;
                end else begin
                    ns_q <= ns_dec;
                    ew_q <= ew_dec;
                end
            end else if (clr_ok) begin
                fault_cause <= '0;
                ns_q        <= ns_dec;
                ew_q        <= ew_dec;
            end else if (fcnt == HALF_LAST) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // In FLASH the lamps come straight from the flash phase; ns_q/ew_q only
    // matter in NORMAL.
    assign fault   = (state == FLASH);
    assign ns_lamp = fault ? {phase, 2'b00} : ns_q;
    assign ew_lamp = fault ? {phase, 2'b00} : ew_q;

endmodule
